// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Freeze/flush sequencer for the five pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//   It detects RAW hazards in ID, applies taken-branch flushes and runs the multi-cycle
//   data-memory handshake. It also keeps saturating stall and flush counters.
//
// Parameters
//   CNT_W    width of o_stall_count / o_flush_count
//   TIMEOUT  MEM_WAIT cycles allowed before the access is aborted; 0 disables the timeout
//
// Ports
//   clk, rst            clock (rising edge); asynchronous active-high reset
//   i_id_*              ID-stage source indices and use flags
//   i_exe_*, i_mem_*    EXE/MEM-stage destination, write-back and load flags
//   i_fwd_en            forwarding unit present: only load-use hazards stall
//   i_branch_taken      EXE-stage branch resolved taken
//   i_mem_access        MEM-stage instruction reads or writes data memory
//   i_mem_ready         single-cycle completion pulse from data memory
//   o_*_freeze/_flush   stage register hold / clear controls
//   o_mem_start         single-cycle request to data memory
//   o_mem_timeout_err   sticky timeout flag, cleared only by rst
//   o_stall_count       cycles with o_pc_freeze=1 (saturating)
//   o_flush_count       branch flushes applied (saturating)

module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       i_id_src1,
    input  logic [3:0]       i_id_src2,
    input  logic             i_id_two_src,
    input  logic             i_id_use_src1,
    input  logic [3:0]       i_exe_dest,
    input  logic             i_exe_wb_en,
    input  logic             i_exe_mem_r_en,
    input  logic [3:0]       i_mem_dest,
    input  logic             i_mem_wb_en,
    input  logic             i_fwd_en,
    input  logic             i_branch_taken,
    input  logic             i_mem_access,
    input  logic             i_mem_ready,
    output logic             o_pc_freeze,
    output logic             o_ifid_freeze,
    output logic             o_ifid_flush,
    output logic             o_idex_freeze,
    output logic             o_idex_flush,
    output logic             o_exmem_freeze,
    output logic             o_memwb_flush,
    output logic             o_mem_start,
    output logic             o_mem_timeout_err,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_flush_count
);

    // The wait counter only needs to reach TIMEOUT-1: the TIMEOUT-th wait cycle is the abort.
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [0:0] {
        StRun,
        StMemWait
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_cnt_next;
    logic               r_timeout_err;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic               w_src1_match;
    logic               w_src2_match;
    logic               w_hazard;
    logic               w_mem_stall;
    logic               w_mem_req;
    logic               w_timeout;
    logic               w_flush_apply;

    // With forwarding, only a load in EXE cannot be bypassed in time.
    always_comb begin
        if (i_fwd_en) begin
            w_src1_match = i_exe_wb_en && i_exe_mem_r_en && (i_id_src1 == i_exe_dest);
            w_src2_match = i_exe_wb_en && i_exe_mem_r_en && (i_id_src2 == i_exe_dest);
        end else begin
            w_src1_match = (i_exe_wb_en && (i_id_src1 == i_exe_dest)) ||
                           (i_mem_wb_en && (i_id_src1 == i_mem_dest));
            w_src2_match = (i_exe_wb_en && (i_id_src2 == i_exe_dest)) ||
                           (i_mem_wb_en && (i_id_src2 == i_mem_dest));
        end
        w_hazard = (i_id_use_src1 && w_src1_match) || (i_id_two_src && w_src2_match);
    end

    // Memory handshake next-state logic.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_mem_stall     = 1'b0;
        w_mem_req       = 1'b0;
        w_timeout       = 1'b0;
        unique case (r_state)
            StRun: begin
                if (i_mem_access) begin
                    w_mem_req       = 1'b1;
                    w_mem_stall     = 1'b1;
                    w_state_next    = StMemWait;
                    w_wait_cnt_next = '0;
                end
            end
            StMemWait: begin
                if (i_mem_ready) begin
                    // Ready cycle: EX/MEM and MEM/WB advance, so no freeze.
                    w_state_next = StRun;
                end else if ((TIMEOUT != 0) && (r_wait_cnt == WAIT_LAST)) begin
                    w_timeout    = 1'b1;
                    w_state_next = StRun;
                end else begin
                    w_mem_stall     = 1'b1;
                    w_wait_cnt_next = r_wait_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = StRun;
            end
        endcase
    end

    // Priority: memory stall > taken branch > RAW hazard. All outputs low during reset.
    always_comb begin
        o_pc_freeze    = 1'b0;
        o_ifid_freeze  = 1'b0;
        o_ifid_flush   = 1'b0;
        o_idex_freeze  = 1'b0;
        o_idex_flush   = 1'b0;
        o_exmem_freeze = 1'b0;
        o_memwb_flush  = 1'b0;
        o_mem_start    = 1'b0;
        w_flush_apply  = 1'b0;
        if (!rst) begin
            if (w_mem_stall) begin
                // The branch stays parked in the frozen ID/EX and is seen again on release.
                o_pc_freeze    = 1'b1;
                o_ifid_freeze  = 1'b1;
                o_idex_freeze  = 1'b1;
                o_exmem_freeze = 1'b1;
                o_memwb_flush  = 1'b1;
                o_mem_start    = w_mem_req;
            end else if (i_branch_taken) begin
                o_ifid_flush  = 1'b1;
                o_idex_flush  = 1'b1;
                w_flush_apply = 1'b1;
            end else if (w_hazard) begin
                o_pc_freeze   = 1'b1;
                o_ifid_freeze = 1'b1;
                o_idex_flush  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StRun;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout_err <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if (o_pc_freeze && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_apply && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign o_mem_timeout_err = r_timeout_err;
    assign o_stall_count     = r_stall_cnt;
    assign o_flush_count     = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Directed scenarios plus a randomized run against a cycle-level reference model.
//   The DUT is built with small counters and a short timeout so saturation and abort are reachable.

module tb_pipeline_hazard_ctrl;

    localparam int unsigned CW = 4;
    localparam int unsigned TO = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    // {pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_flush, exmem_freeze, memwb_flush, mem_start}
    localparam logic [7:0] OUT_NONE  = 8'b0000_0000;
    localparam logic [7:0] OUT_STALL = 8'b1101_0110;
    localparam logic [7:0] OUT_START = 8'b1101_0111;
    localparam logic [7:0] OUT_HAZ   = 8'b1100_1000;
    localparam logic [7:0] OUT_BR    = 8'b0010_1000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    i_id_src1, i_id_src2, i_exe_dest, i_mem_dest;
    logic          i_id_two_src, i_id_use_src1, i_exe_wb_en, i_exe_mem_r_en, i_mem_wb_en;
    logic          i_fwd_en, i_branch_taken, i_mem_access, i_mem_ready;
    logic          o_pc_freeze, o_ifid_freeze, o_ifid_flush, o_idex_freeze, o_idex_flush;
    logic          o_exmem_freeze, o_memwb_flush, o_mem_start, o_mem_timeout_err;
    logic [CW-1:0] o_stall_count, o_flush_count;
    logic [7:0]    outs;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_busy;
    int m_wait;
    bit m_err;
    int m_stall;
    int m_flush;

    always #5 clk = ~clk;

    assign outs = {o_pc_freeze, o_ifid_freeze, o_ifid_flush, o_idex_freeze, o_idex_flush,
                   o_exmem_freeze, o_memwb_flush, o_mem_start};

    pipeline_hazard_ctrl #(
        .CNT_W   (CW),
        .TIMEOUT (TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_id_src1         (i_id_src1),
        .i_id_src2         (i_id_src2),
        .i_id_two_src      (i_id_two_src),
        .i_id_use_src1     (i_id_use_src1),
        .i_exe_dest        (i_exe_dest),
        .i_exe_wb_en       (i_exe_wb_en),
        .i_exe_mem_r_en    (i_exe_mem_r_en),
        .i_mem_dest        (i_mem_dest),
        .i_mem_wb_en       (i_mem_wb_en),
        .i_fwd_en          (i_fwd_en),
        .i_branch_taken    (i_branch_taken),
        .i_mem_access      (i_mem_access),
        .i_mem_ready       (i_mem_ready),
        .o_pc_freeze       (o_pc_freeze),
        .o_ifid_freeze     (o_ifid_freeze),
        .o_ifid_flush      (o_ifid_flush),
        .o_idex_freeze     (o_idex_freeze),
        .o_idex_flush      (o_idex_flush),
        .o_exmem_freeze    (o_exmem_freeze),
        .o_memwb_flush     (o_memwb_flush),
        .o_mem_start       (o_mem_start),
        .o_mem_timeout_err (o_mem_timeout_err),
        .o_stall_count     (o_stall_count),
        .o_flush_count     (o_flush_count)
    );

    task automatic clear_inputs();
        i_id_src1 = 4'd0; i_id_src2 = 4'd0; i_id_two_src = 1'b0; i_id_use_src1 = 1'b0;
        i_exe_dest = 4'd0; i_exe_wb_en = 1'b0; i_exe_mem_r_en = 1'b0;
        i_mem_dest = 4'd0; i_mem_wb_en = 1'b0; i_fwd_en = 1'b0;
        i_branch_taken = 1'b0; i_mem_access = 1'b0; i_mem_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // EXE instruction writes r3, ID instruction reads r3 through src1.
    task automatic set_exe_raw();
        i_exe_dest = 4'd3; i_exe_wb_en = 1'b1; i_id_src1 = 4'd3; i_id_use_src1 = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        set_exe_raw();
        i_mem_access = 1'b1;
        i_branch_taken = 1'b1;
        #2;
        checks++;
        if (outs !== OUT_NONE) begin
            errors++; $display("FAIL reset_outs: got %b want %b", outs, OUT_NONE);
        end
        @(posedge clk);
        #1;
        checks++;
        if (o_stall_count !== 4'd0 || o_flush_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_counts: got %0d/%0d want 0/0", o_stall_count, o_flush_count);
        end
        checks++;
        if (o_mem_timeout_err !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b want 0", o_mem_timeout_err);
        end
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (outs !== OUT_NONE) begin
            errors++; $display("FAIL reset_idle_outs: got %b want %b", outs, OUT_NONE);
        end
    endtask

    task automatic test_hazard_nofwd();
        apply_reset();
        set_exe_raw();
        @(negedge clk);
        checks++;
        if (outs !== OUT_HAZ || o_stall_count !== 4'd0) begin
            errors++;
            $display("FAIL hazard_nofwd: got %b cnt %0d want %b cnt 0", outs, o_stall_count, OUT_HAZ);
        end
        next_cycle();
        clear_inputs();
        // MEM-stage match through src2 also stalls without forwarding.
        i_mem_dest = 4'd9; i_mem_wb_en = 1'b1; i_id_src2 = 4'd9; i_id_two_src = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== OUT_HAZ || o_stall_count !== 4'd1) begin
            errors++;
            $display("FAIL hazard_mem_src2: got %b cnt %0d want %b cnt 1", outs, o_stall_count,
                     OUT_HAZ);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (outs !== OUT_NONE || o_stall_count !== 4'd2) begin
            errors++;
            $display("FAIL hazard_release: got %b cnt %0d want %b cnt 2", outs, o_stall_count,
                     OUT_NONE);
        end
    endtask

    task automatic test_fwd();
        apply_reset();
        set_exe_raw();
        i_fwd_en = 1'b1;
        i_mem_dest = 4'd3; i_mem_wb_en = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== OUT_NONE) begin
            errors++; $display("FAIL fwd_no_load: got %b want %b", outs, OUT_NONE);
        end
        next_cycle();
        i_exe_mem_r_en = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== OUT_HAZ) begin
            errors++; $display("FAIL fwd_load_use: got %b want %b", outs, OUT_HAZ);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (o_stall_count !== 4'd1) begin
            errors++; $display("FAIL fwd_stall_count: got %0d want 1", o_stall_count);
        end
    endtask

    task automatic test_mem_ready();
        apply_reset();
        i_mem_access = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== OUT_START) begin
            errors++; $display("FAIL mem_start_cycle: got %b want %b", outs, OUT_START);
        end
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (outs !== OUT_STALL) begin
                errors++; $display("FAIL mem_wait_%0d: got %b want %b", k, outs, OUT_STALL);
            end
        end
        next_cycle();
        i_mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== OUT_NONE) begin
            errors++; $display("FAIL mem_ready_release: got %b want %b", outs, OUT_NONE);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (outs !== OUT_NONE || o_stall_count !== 4'd4) begin
            errors++;
            $display("FAIL mem_after: got %b cnt %0d want %b cnt 4", outs, o_stall_count, OUT_NONE);
        end
    endtask

    task automatic test_branch_hazard();
        apply_reset();
        set_exe_raw();
        i_branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== OUT_BR) begin
            errors++; $display("FAIL branch_over_hazard: got %b want %b", outs, OUT_BR);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (o_flush_count !== 4'd1 || o_stall_count !== 4'd0) begin
            errors++;
            $display("FAIL branch_counts: got %0d/%0d want flush 1 stall 0", o_flush_count,
                     o_stall_count);
        end
    endtask

    task automatic test_branch_in_wait();
        apply_reset();
        i_mem_access = 1'b1;
        @(negedge clk);
        next_cycle();
        i_branch_taken = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            checks++;
            if (outs !== OUT_STALL) begin
                errors++; $display("FAIL branch_wait_%0d: got %b want %b", k, outs, OUT_STALL);
            end
            next_cycle();
        end
        i_mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== OUT_BR) begin
            errors++; $display("FAIL branch_on_ready: got %b want %b", outs, OUT_BR);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (o_flush_count !== 4'd1 || o_stall_count !== 4'd3) begin
            errors++;
            $display("FAIL branch_wait_counts: got %0d/%0d want flush 1 stall 3", o_flush_count,
                     o_stall_count);
        end
    endtask

    // Leaves err set so the following reset test can see it cleared.
    task automatic test_timeout();
        apply_reset();
        i_mem_access = 1'b1;
        @(negedge clk);
        for (int k = 1; k < int'(TO); k++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (outs !== OUT_STALL || o_mem_timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait_%0d: got %b err %b want %b err 0", k, outs,
                         o_mem_timeout_err, OUT_STALL);
            end
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (outs !== OUT_NONE) begin
            errors++; $display("FAIL timeout_release: got %b want %b", outs, OUT_NONE);
        end
        next_cycle();
        i_mem_access = 1'b0;
        @(negedge clk);
        checks++;
        if (o_mem_timeout_err !== 1'b1 || outs !== OUT_NONE || o_stall_count !== 4'd4) begin
            errors++;
            $display("FAIL timeout_after: err %b outs %b cnt %0d want err 1 outs %b cnt 4",
                     o_mem_timeout_err, outs, o_stall_count, OUT_NONE);
        end
    endtask

    task automatic test_rst_midwait();
        next_cycle();
        i_mem_access = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== OUT_START) begin
            errors++; $display("FAIL rmw_start: got %b want %b", outs, OUT_START);
        end
        next_cycle();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== OUT_NONE || o_mem_timeout_err !== 1'b0 || o_stall_count !== 4'd0) begin
            errors++;
            $display("FAIL rmw_in_reset: outs %b err %b cnt %0d want %b 0 0", outs,
                     o_mem_timeout_err, o_stall_count, OUT_NONE);
        end
        next_cycle();
        rst = 1'b0;
        i_mem_access = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (outs !== OUT_NONE) begin
                errors++; $display("FAIL rmw_after_%0d: got %b want %b", k, outs, OUT_NONE);
            end
            next_cycle();
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        set_exe_raw();
        repeat (CNT_MAX + 3) next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (o_stall_count !== 4'hF) begin
            errors++; $display("FAIL stall_saturate: got %0d want 15", o_stall_count);
        end
        next_cycle();
        i_branch_taken = 1'b1;
        repeat (CNT_MAX + 2) next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (o_flush_count !== 4'hF || o_stall_count !== 4'hF) begin
            errors++;
            $display("FAIL flush_saturate: got %0d/%0d want 15/15", o_flush_count, o_stall_count);
        end
    endtask

    function automatic bit src_hits(input logic [3:0] s);
        if (i_fwd_en) return i_exe_wb_en && i_exe_mem_r_en && (s == i_exe_dest);
        return (i_exe_wb_en && (s == i_exe_dest)) || (i_mem_wb_en && (s == i_mem_dest));
    endfunction

    function automatic logic [3:0] rand_reg();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 3));
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_wait = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    endtask

    task automatic test_random();
        logic [7:0]  eo;
        logic [16:0] exp_v, got_v;
        bit hz, start, tmo, stall, br_apply;
        apply_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 250 == 249) begin
                rst = 1'b1;
                clear_inputs();
            end else begin
                rst = 1'b0;
                i_id_src1 = rand_reg(); i_id_src2 = rand_reg();
                i_exe_dest = rand_reg(); i_mem_dest = rand_reg();
                i_id_two_src = 1'($urandom_range(0, 1)); i_id_use_src1 = 1'($urandom_range(0, 1));
                i_exe_wb_en = 1'($urandom_range(0, 1)); i_exe_mem_r_en = 1'($urandom_range(0, 1));
                i_mem_wb_en = 1'($urandom_range(0, 1)); i_fwd_en = 1'($urandom_range(0, 1));
                i_branch_taken = ($urandom_range(0, 5) == 0);
                i_mem_access = ($urandom_range(0, 3) == 0);
                i_mem_ready = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            hz = (i_id_use_src1 && src_hits(i_id_src1)) || (i_id_two_src && src_hits(i_id_src2));
            start = !m_busy && i_mem_access;
            tmo = m_busy && !i_mem_ready && (m_wait + 1 == int'(TO));
            stall = start || (m_busy && !i_mem_ready && !tmo);
            br_apply = !stall && i_branch_taken;
            if (rst) eo = OUT_NONE;
            else if (stall) eo = start ? OUT_START : OUT_STALL;
            else if (i_branch_taken) eo = OUT_BR;
            else if (hz) eo = OUT_HAZ;
            else eo = OUT_NONE;
            exp_v = rst ? 17'd0 : {eo, m_err, CW'(m_stall), CW'(m_flush)};
            got_v = {outs, o_mem_timeout_err, o_stall_count, o_flush_count};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random cyc %0d: got outs %b err %b cnt %0d/%0d want %b %b %0d/%0d",
                         cyc, got_v[16:9], got_v[8], got_v[7:4], got_v[3:0], exp_v[16:9],
                         exp_v[8], exp_v[7:4], exp_v[3:0]);
            end
            if (rst) begin
                model_reset();
            end else begin
                if (eo[7] && m_stall < CNT_MAX) m_stall++;
                if (br_apply && m_flush < CNT_MAX) m_flush++;
                if (start) begin
                    m_busy = 1'b1; m_wait = 0;
                end else if (m_busy) begin
                    if (i_mem_ready) m_busy = 1'b0;
                    else if (tmo) begin m_busy = 1'b0; m_err = 1'b1; end
                    else m_wait++;
                end
            end
            next_cycle();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_hazard_nofwd();
        test_fwd();
        test_mem_ready();
        test_branch_hazard();
        test_branch_in_wait();
        test_timeout();
        test_rst_midwait();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
